// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between imem and the IF/ID register.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        entry_d[wr_ptr_q] = push_data_i;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign head_o  = entry_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch.sv
// IF stage: PC register, single-outstanding imem fetch FSM, 2-entry buffer and IF/ID register.
//  state  | meaning
//  S_REQ  | no fetch outstanding; request pc when the queue has a free slot
//  S_WAIT | fetch granted; next rvalid is pushed (or bypassed to IF/ID)
//  S_DROP | fetch granted but made stale by a redirect; next rvalid is discarded
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         misalign_q, misalign_d;

  logic         outstanding;
  logic         credit;
  logic         req;
  logic         fire;
  logic         resp_live;
  logic         bypass;
  logic         q_push, q_pop;
  fetch_entry_t q_head;
  logic [1:0]   q_count;
  logic         q_full, q_empty;

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (q_push),
    .push_data_i ('{pc: req_pc_q, instr: imem_rdata_i}),
    .pop_i       (q_pop),
    .flush_i     (redirect_i),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    outstanding = (state_q != S_REQ);
    // Buffered + in-flight must stay below 2 so every response has a slot.
    credit      = ({1'b0, q_count} + {2'b00, outstanding}) < 3'd2;
    req         = rst_n && (state_q == S_REQ) && credit;
    fire        = req && imem_gnt_i;
    resp_live   = imem_rvalid_i && (state_q == S_WAIT) && !redirect_i;
    bypass      = resp_live && !stall_i && q_empty;
    q_push      = resp_live && !bypass;
    q_pop       = 1'b0;

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = fire ? pc_q : req_pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    case (state_q)
      S_REQ: begin
        if (fire) begin
          state_d = redirect_i ? S_DROP : S_WAIT;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        // A response landing in the redirect cycle closes the fetch; nothing left to drop.
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_i) begin
      pc_d     = word_align(redirect_pc_i);
      instr_d  = NOP_INSTR;
      pc_out_d = 32'd0;
      valid_d  = 1'b0;
    end else if (!stall_i) begin
      if (!q_empty) begin
        instr_d  = q_head.instr;
        pc_out_d = q_head.pc;
        valid_d  = 1'b1;
        q_pop    = 1'b1;
      end else if (bypass) begin
        instr_d  = imem_rdata_i;
        pc_out_d = req_pc_q;
        valid_d  = 1'b1;
      end else begin
        instr_d  = NOP_INSTR;
        pc_out_d = 32'd0;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;

endmodule
